// File: rtl/golay24_enc_packer_pkg.sv
// golay24 shared package
// Purpose : phase encoding and width constants shared by the golay24
//           byte-to-word packer and the blocks that consume its output.
// Contents: BYTE_W  - input byte width (8)
//           WORD_W  - encoder information word width (12)
//           phase_t - packer phase (PH0, PH1, PH2, FLUSH)
package golay24_enc_packer_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 12;

  typedef enum logic [1:0] {
    PH0   = 2'd0,
    PH1   = 2'd1,
    PH2   = 2'd2,
    FLUSH = 2'd3
  } phase_t;

endpackage

// File: rtl/golay24_enc_packer.sv
// golay24_enc_packer
// Purpose : packs a byte stream (MSB first) into 12-bit information words for
//           the golay24 encoder. Three bytes make two words; a frame ending on
//           a word boundary mid-byte is zero-padded.
// Ports   : iclk, ireset (async, active-high), iclkena (global clock enable)
//           ival/isop/ieop/itag/idat - byte input, accepted when ival & ordy & iclkena
//           ordy                      - low only during the single FLUSH cycle
//           oval/osop/oeop/otag/odat  - registered word output, no backpressure
//           opad                      - word contains zero padding
//                                       (only with GOLAY24_ENC_PACKER_PADFLAG_EN)
//
// state | meaning
// PH0   | waiting for b0 of a byte triplet
// PH1   | b0 held, waiting for b1
// PH2   | b1[3:0] held, waiting for b2
// FLUSH | frame ended on b1; emit {b1[3:0],8'h0} and refuse input this cycle
module golay24_enc_packer
  import golay24_enc_packer_pkg::*;
#(
  parameter int pTAG_W = 1
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  logic              ival,
  input  logic              isop,
  input  logic              ieop,
  input  logic [pTAG_W-1:0] itag,
  input  logic [BYTE_W-1:0] idat,
  output logic              ordy,
  output logic              oval,
  output logic              osop,
  output logic              oeop,
  output logic [pTAG_W-1:0] otag,
  output logic [WORD_W-1:0] odat
`ifdef GOLAY24_ENC_PACKER_PADFLAG_EN
  ,
  output logic              opad
`endif
);

  phase_t              r_ph;
  logic [BYTE_W-1:0]   r_hold;
  logic                r_pend;
  logic                r_rdy;
  logic                r_oval;
  logic                r_osop;
  logic                r_oeop;
  logic [WORD_W-1:0]   r_odat;
  logic [pTAG_W-1:0]   r_otag;
  logic [pTAG_W-1:0]   r_tag_hold;

  logic                w_acc;
  logic                w_ld;
  logic                w_sop;
  logic                w_eop;
  logic [WORD_W-1:0]   w_dat;
  logic [pTAG_W-1:0]   w_tag;
  phase_t              w_ph_nxt;
  logic [BYTE_W-1:0]   w_hold_nxt;
  logic                w_pend_nxt;
  logic                w_rdy_nxt;

  assign w_acc = iclkena & ival & r_rdy;

  always_comb begin
    w_ld       = 1'b0;
    w_sop      = 1'b0;
    w_eop      = 1'b0;
    w_dat      = r_odat;
    w_tag      = r_otag;
    w_ph_nxt   = r_ph;
    w_hold_nxt = r_hold;
    w_pend_nxt = r_pend;
    w_rdy_nxt  = r_rdy;

    if (r_ph == FLUSH) begin
      // trailing half-word of a frame that ended on b1; tag is b1's
      w_ld       = 1'b1;
      w_dat      = {r_hold[3:0], 8'h00};
      w_tag      = r_tag_hold;
      w_eop      = 1'b1;
      w_ph_nxt   = PH0;
      w_rdy_nxt  = 1'b1;
      w_hold_nxt = '0;
    end else if (w_acc) begin
      // a sop byte always restarts as b0, discarding any held bits
      if (isop || (r_ph == PH0)) begin
        if (ieop) begin
          w_ld       = 1'b1;
          w_dat      = {idat, 4'h0};
          w_tag      = itag;
          w_sop      = isop;
          w_eop      = 1'b1;
          w_ph_nxt   = PH0;
          w_pend_nxt = 1'b0;
          w_hold_nxt = '0;
        end else begin
          w_hold_nxt = idat;
          w_pend_nxt = isop;
          w_ph_nxt   = PH1;
        end
      end else if (r_ph == PH1) begin
        w_ld       = 1'b1;
        w_dat      = {r_hold, idat[7:4]};
        w_tag      = itag;
        w_sop      = r_pend;
        w_pend_nxt = 1'b0;
        w_hold_nxt = {4'h0, idat[3:0]};
        if (ieop) begin
          w_ph_nxt  = FLUSH;
          w_rdy_nxt = 1'b0;
        end else begin
          w_ph_nxt  = PH2;
        end
      end else begin
        w_ld       = 1'b1;
        w_dat      = {r_hold[3:0], idat};
        w_tag      = itag;
        w_sop      = r_pend;
        w_eop      = ieop;
        w_pend_nxt = 1'b0;
        w_ph_nxt   = PH0;
        w_hold_nxt = '0;
      end
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      r_ph   <= PH0;
      r_hold <= '0;
      r_pend <= 1'b0;
      r_rdy  <= 1'b1;
      r_oval <= 1'b0;
      r_osop <= 1'b0;
      r_oeop <= 1'b0;
    end else if (iclkena) begin
      r_ph   <= w_ph_nxt;
      r_hold <= w_hold_nxt;
      r_pend <= w_pend_nxt;
      r_rdy  <= w_rdy_nxt;
      r_oval <= w_ld;
      r_osop <= w_sop;
      r_oeop <= w_eop;
    end
  end

  // word payload and tags are qualified by oval, so they need no reset
  always_ff @(posedge iclk) begin
    if (iclkena && w_ld) begin
      r_odat <= w_dat;
      r_otag <= w_tag;
    end
    if (w_acc && (r_ph == PH1) && !isop) begin
      r_tag_hold <= itag;
    end
  end

`ifdef GOLAY24_ENC_PACKER_PADFLAG_EN
  logic w_pad;
  logic r_opad;

  // padded words: the FLUSH word and any word emitted from a lone b0 with eop
  assign w_pad = (r_ph == FLUSH) || (w_acc && ieop && (isop || (r_ph == PH0)));

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      r_opad <= 1'b0;
    end else if (iclkena) begin
      r_opad <= w_pad;
    end
  end

  assign opad = r_opad;
`endif

  assign ordy = r_rdy;
  assign oval = r_oval;
  assign osop = r_osop;
  assign oeop = r_oeop;
  assign odat = r_odat;
  assign otag = r_otag;

endmodule

// File: tb/tb_golay24_enc_packer.sv
// Testbench for golay24_enc_packer: directed byte frames, expected words queued
// at drive time and popped by a monitor whenever a fresh word appears.
module tb_golay24_enc_packer;

  logic        iclk = 1'b0;
  logic        ireset;
  logic        iclkena;
  logic        ival;
  logic        isop;
  logic        ieop;
  logic [0:0]  itag;
  logic [7:0]  idat;
  logic        ordy;
  logic        oval;
  logic        osop;
  logic        oeop;
  logic [0:0]  otag;
  logic [11:0] odat;
  logic        pad_obs;

  golay24_enc_packer #(.pTAG_W(1)) dut (
    .iclk    (iclk),
    .ireset  (ireset),
    .iclkena (iclkena),
    .ival    (ival),
    .isop    (isop),
    .ieop    (ieop),
    .itag    (itag),
    .idat    (idat),
    .ordy    (ordy),
    .oval    (oval),
    .osop    (osop),
    .oeop    (oeop),
    .otag    (otag),
    .odat    (odat)
`ifdef GOLAY24_ENC_PACKER_PADFLAG_EN
    ,
    .opad    (pad_obs)
`endif
  );

  always #5 iclk = ~iclk;

  typedef struct packed {
    logic [11:0] d;
    logic        s;
    logic        e;
    logic        p;
    logic [0:0]  t;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  logic en_q   = 1'b0;
  logic gate_mode = 1'b0;

  always @(posedge iclk) en_q <= iclkena;

  // a word is fresh at the negedge following an enabled posedge
  always @(negedge iclk) begin
    if (!ireset && en_q && oval) begin
      exp_t e;
      exp_t g;
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_word got dat=%h sop=%b eop=%b required none", odat, osop, oeop);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
`ifdef GOLAY24_ENC_PACKER_PADFLAG_EN
        g = '{d: odat, s: osop, e: oeop, p: pad_obs, t: otag};
`else
        g = '{d: odat, s: osop, e: oeop, p: e.p, t: otag};
`endif
        checks++;
        assert (g === e) else begin
          errors++;
          $error("FAIL word got dat=%h sop=%b eop=%b pad=%b tag=%b required dat=%h sop=%b eop=%b pad=%b tag=%b",
                 g.d, g.s, g.e, g.p, g.t, e.d, e.s, e.e, e.p, e.t);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h required=%h", nm, got, exp);
    end
  endtask

  task automatic push(input logic [11:0] d, input logic s, input logic e, input logic p, input logic t);
    q.push_back('{d: d, s: s, e: e, p: p, t: t});
  endtask

  // called and returns at posedge+1; returns just after the accepting edge
  task automatic send(input logic [7:0] d, input logic s, input logic e, input logic t);
    logic acc = 1'b0;
    ival = 1'b1; idat = d; isop = s; ieop = e; itag = t;
    for (int n = 0; n < 50 && !acc; n++) begin
      if (gate_mode) iclkena = (n >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
      acc = ordy && iclkena;
      @(posedge iclk); #1;
    end
    ival = 1'b0; isop = 1'b0; ieop = 1'b0;
    iclkena = 1'b1;
    checks++;
    assert (acc) else begin
      errors++;
      $error("FAIL accept_timeout byte=%h got not_accepted required accepted", d);
    end
  endtask

  task automatic idle(input int n);
    ival = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gate_mode) iclkena = 1'($urandom_range(0, 1));
      @(posedge iclk); #1;
    end
    iclkena = 1'b1;
  endtask

  task automatic frame_a53();
    send(8'hA5, 1'b1, 1'b0, 1'b0);
    push(12'hA53, 1'b1, 1'b0, 1'b0, 1'b1);
    send(8'h3C, 1'b0, 1'b0, 1'b1);
    push(12'hCF0, 1'b0, 1'b1, 1'b0, 1'b0);
    send(8'hF0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic frame_flush();
    push(12'h123, 1'b1, 1'b0, 1'b0, 1'b1);
    push(12'h400, 1'b0, 1'b1, 1'b1, 1'b1);
    send(8'h12, 1'b1, 1'b0, 1'b0);
    send(8'h34, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic frame_abort();
    send(8'h11, 1'b1, 1'b0, 1'b1);
    push(12'h112, 1'b1, 1'b0, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0, 1'b0);
    send(8'h33, 1'b1, 1'b0, 1'b0);
    push(12'h334, 1'b1, 1'b0, 1'b0, 1'b1);
    send(8'h44, 1'b0, 1'b0, 1'b1);
    push(12'h455, 1'b0, 1'b1, 1'b0, 1'b0);
    send(8'h55, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ireset = 1'b1; iclkena = 1'b1; ival = 1'b0; isop = 1'b0; ieop = 1'b0;
    itag = 1'b0; idat = 8'h00;
    repeat (2) @(posedge iclk);
    #1;
    chk("rst_oval", 16'(oval), 16'h0);
    chk("rst_osop", 16'(osop), 16'h0);
    chk("rst_oeop", 16'(oeop), 16'h0);
    chk("rst_ordy", 16'(ordy), 16'h1);
    ireset = 1'b0;
    idle(2);

    // three-byte frame with one-cycle word latency
    send(8'hA5, 1'b1, 1'b0, 1'b0);
    push(12'hA53, 1'b1, 1'b0, 1'b0, 1'b1);
    send(8'h3C, 1'b0, 1'b0, 1'b1);
    chk("lat_w0_oval", 16'(oval), 16'h1);
    chk("lat_w0_odat", 16'(odat), 16'hA53);
    push(12'hCF0, 1'b0, 1'b1, 1'b0, 1'b0);
    send(8'hF0, 1'b0, 1'b1, 1'b0);
    chk("lat_w1_oval", 16'(oval), 16'h1);
    chk("lat_w1_odat", 16'(odat), 16'hCF0);
    idle(3);

    // eop on b1: FLUSH holds ordy low for exactly one enabled cycle
    frame_flush();
    chk("flush_ordy_low", 16'(ordy), 16'h0);
    @(posedge iclk); #1;
    chk("flush_ordy_high", 16'(ordy), 16'h1);
    chk("flush_word", 16'(odat), 16'h400);
    idle(3);

    // single byte sop+eop, then outputs hold while iclkena is low
    push(12'h7E0, 1'b1, 1'b1, 1'b1, 1'b1);
    send(8'h7E, 1'b1, 1'b1, 1'b1);
    iclkena = 1'b0;
    repeat (3) begin @(posedge iclk); #1; end
    chk("hold_oval", 16'(oval), 16'h1);
    chk("hold_odat", 16'(odat), 16'h7E0);
    chk("hold_osop", 16'(osop), 16'h1);
    chk("hold_oeop", 16'(oeop), 16'h1);
    iclkena = 1'b1;
    idle(2);

    // sop mid-triplet aborts the held nibble
    frame_abort();
    idle(3);

    // lone b0 with eop and no sop
    push(12'hA10, 1'b0, 1'b1, 1'b1, 1'b0);
    send(8'hA1, 1'b0, 1'b1, 1'b0);
    idle(3);

    // reset during FLUSH: outputs clear at once, no trailing word
    send(8'h12, 1'b1, 1'b0, 1'b0);
    send(8'h34, 1'b0, 1'b1, 1'b1);
    ireset = 1'b1;
    #1;
    chk("rst_flush_oval", 16'(oval), 16'h0);
    chk("rst_flush_ordy", 16'(ordy), 16'h1);
    @(posedge iclk); #1;
    ireset = 1'b0;
    idle(6);
    chk("rst_flush_no_word", 16'(q.size()), 16'h0);

    // same frames with random clock-enable gating
    gate_mode = 1'b1;
    frame_a53();
    idle(4);
    frame_flush();
    idle(4);
    frame_abort();
    idle(10);
    gate_mode = 1'b0;
    idle(5);

    chk("queue_drained", 16'(q.size()), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/golay24_enc_packer.md
GOLAY24_ENC_PACKER -- requirements
Module: golay24_enc_packer

Interface
REQ-001 Parameter pTAG_W, default 1, sets the width of the per-word tag carried alongside the data.
REQ-002 iclk  in  1  Single clock; all logic is rising-edge.
REQ-003 ireset  in  1  Reset, asynchronous, active-high.
REQ-004 iclkena  in  1  Clock enable; when low, all state and outputs hold.
REQ-005 ival  in  1  Input byte valid.
REQ-006 isop  in  1  First byte of a frame; qualified by ival.
REQ-007 ieop  in  1  Last byte of a frame; qualified by ival.
REQ-008 itag  in  pTAG_W  Byte tag.
REQ-009 idat  in  8  Input byte, MSB first.
REQ-010 ordy  out  1  Ready; a byte is accepted only when ival=1, ordy=1 and iclkena=1.
REQ-011 oval  out  1  Output 12-bit word valid; this is the encoder's ival.
REQ-012 osop  out  1  First word of a frame.
REQ-013 oeop  out  1  Last word of a frame.
REQ-014 otag  out  pTAG_W  Tag of the byte that completed the word.
REQ-015 odat  out  12  Information word for the encoder, MSB = first bit received.

Function
REQ-016 Packing: three accepted bytes b0,b1,b2 shall produce two words: W0={b0,b1[7:4]} and W1={b1[3:0],b2}.
REQ-017 Phase counter: states PH0, PH1, PH2 and FLUSH. Transitions on accept: PH0->PH1, PH1->PH2, PH2->PH0.
REQ-018 Word emission: W0 on acceptance of b1; W1 on acceptance of b2. Latency is one cycle: the output registers are valid in the cycle after the completing byte is accepted.
REQ-019 oval shall be high for exactly one enabled cycle per word. The block has no output backpressure.
REQ-020 EOP in PH0 (byte b0): emit {b0,4'h0} with oeop=1 next cycle; next state PH0.
REQ-021 EOP in PH1 (byte b1): emit W0 next cycle. Enter FLUSH with ordy=0 for one enabled cycle, then emit {b1[3:0],8'h0} with oeop=1. Return to PH0 and set ordy=1.
REQ-022 EOP in PH2: emit W1 with oeop=1; next state PH0.
REQ-023 isop on an accepted byte in PH1 or PH2 shall abort the partial word. The held bits are discarded, no word is emitted for them, and the byte is treated as b0 in PH0.
REQ-024 isop and ieop on the same byte: emit a single word {b,4'h0} with osop=1 and oeop=1.
REQ-025 osop shall be asserted on the first word emitted after an accepted isop byte.
REQ-026 ival while ordy=0 shall be ignored; upstream must hold the byte until ordy=1.
REQ-027 With iclkena=0: no accept, no state change, and oval, odat, otag, osop and oeop hold their values.

Reset
REQ-028 On ireset: oval=0, osop=0, oeop=0, ordy=1, state=PH0, held bits cleared.
REQ-029 odat and otag are not reset.
REQ-030 Reset asserted mid-frame or during FLUSH shall discard the partial frame; no word is emitted after release.

Configuration
REQ-031 Macro GOLAY24_ENC_PACKER_PADFLAG_EN.
- Defined: adds output port opad (1 bit, reset 0), high with oval on any word containing zero padding, i.e. words from REQ-020, REQ-021 (second word) and REQ-024.
- Undefined: the port is absent and the behaviour is otherwise identical.

Structure
REQ-032 The phase enum (PH0, PH1, PH2, FLUSH) and the localparams for byte width (8) and word width (12) belong in the shared golay24 package.
REQ-033 Single flat module; no sub-module. Its output connects directly to golay24_enc ival, itag and idat, with otag widened as needed to carry sop/eop.

Verification
REQ-034 Bytes A5,3C,F0 with sop on the first and eop on the last -> words A53 (osop), CF0 (oeop), one cycle after bytes 2 and 3.
REQ-035 Bytes 12,34 with sop/eop (eop in PH1) -> ordy low one cycle; words 123 then 400 (oeop, opad=1 if macro defined).
REQ-036 Single byte 7E with isop and ieop together -> one word 7E0 with osop=1, oeop=1.
REQ-037 Bytes 11,22 then a new sop byte 33 and bytes 44,55 with eop -> 112 emitted; the held 2 is discarded; then 334 (osop), 455 (oeop).
REQ-038 Assert ireset during FLUSH -> oval=0 and ordy=1 immediately, no trailing word; iclkena toggled low mid-frame -> output stream identical to the ungated run, only stretched in time.
